// File: rtl/imem_fill_pkg.sv
// Shared hart constants for the instruction line-fill path: line/beat geometry
// and the fill engine state encoding.
package imem_fill_pkg;

  localparam int ADDR_W      = 64;
  localparam int LINE_W      = 1024;
  localparam int BEAT_W      = 64;
  localparam int NBEAT       = LINE_W / BEAT_W;
  localparam int OFFS_W      = 7;
  localparam int BEAT_IDX_W  = $clog2(NBEAT);
  localparam int BYTE_OFFS_W = $clog2(BEAT_W / 8);
  localparam int TAG_W       = ADDR_W - OFFS_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/imem_fill.sv
// Instruction cache line-fill engine: fetches a 1024-bit line as 16 sequential
// 64-bit beats and hands it to the cache with a single-cycle b_dv pulse.
module imem_fill
  import imem_fill_pkg::*;
(
  input  logic              clk,
  input  logic              clr_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              b_rd,
  output logic [LINE_W-1:0] b_data,
  output logic              b_dv,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_rd,
  input  logic [BEAT_W-1:0] m_data,
  input  logic              m_ack
);

  fill_state_e             state_q, state_d;
  logic [TAG_W-1:0]        line_q;
  logic [BEAT_IDX_W-1:0]   beat_q;
  logic [LINE_W-1:0]       buf_q;
  logic                    beat_done;
  logic                    last_beat;
  logic [TAG_W-1:0]        pc_line;
  logic                    unused_pc_offs;

  assign pc_line        = pc[ADDR_W-1:OFFS_W];
  assign unused_pc_offs = ^pc[OFFS_W-1:0];
  assign beat_done      = (state_q == FILL) && m_ack;
  assign last_beat      = (beat_q == BEAT_IDX_W'(NBEAT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path through it can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    m_rd    = 1'b0;
    b_dv    = 1'b0;
    unique case (state_q)
      IDLE: if (b_rd) state_d = FILL;
      FILL: begin
        m_rd = 1'b1;
        if (m_ack && last_beat) state_d = DONE;
      end
      // Deliver only if the cache still wants this very line; otherwise drop it
      // so stale data is never written under a different tag.
      DONE: begin
        b_dv    = b_rd && (pc_line == line_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      line_q <= '0;
      beat_q <= '0;
    end else if (state_q == IDLE && b_rd) begin
      line_q <= pc_line;
      beat_q <= '0;
    end else if (beat_done) begin
      beat_q <= beat_q + BEAT_IDX_W'(1);
    end
  end

  // NOTE: the line buffer is reset on purpose: b_data must read zero after
  // reset, including a reset that aborts a partially filled line.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      buf_q <= '0;
    end else begin
      for (int k = 0; k < NBEAT; k++) begin
        if (beat_done && beat_q == BEAT_IDX_W'(k))
          buf_q[k*BEAT_W +: BEAT_W] <= m_data;
      end
    end
  end

  assign m_addr = {line_q, beat_q, {BYTE_OFFS_W{1'b0}}};
  assign b_data = buf_q;

endmodule

// File: tb/tb_imem_fill.sv
// Self-checking bench for imem_fill: table-driven zero-wait fill plus directed
// sequences for wait states, redirect, reset abort, back-to-back and drop.
module tb_imem_fill;
  import imem_fill_pkg::*;

  logic              clk;
  logic              clr_n;
  logic [63:0]       pc;
  logic              b_rd;
  logic [LINE_W-1:0] b_data;
  logic              b_dv;
  logic [63:0]       m_addr;
  logic              m_rd;
  logic [63:0]       m_data;
  logic              m_ack;

  int n_checks = 0;
  int n_errors = 0;

  imem_fill dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .pc     (pc),
    .b_rd   (b_rd),
    .b_data (b_data),
    .b_dv   (b_dv),
    .m_addr (m_addr),
    .m_rd   (m_rd),
    .m_data (m_data),
    .m_ack  (m_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        b_rd;
    logic        m_ack;
    logic [63:0] m_data;
    logic        exp_m_rd;
    logic        exp_b_dv;
    logic        chk_addr;
    logic [63:0] exp_m_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] word(input int k, input logic [31:0] salt);
    return {salt, 32'(k)};
  endfunction

  task automatic check_line(input string tag, input logic [31:0] salt);
    for (int k = 0; k < NBEAT; k++)
      check($sformatf("%s b_data[%0d]", tag, k), b_data[k*64 +: 64], word(k, salt));
  endtask

  task automatic check_line_zero(input string tag);
    check({tag, " b_data zero"}, 64'(|b_data), 64'd0);
  endtask

  // Drives nbeats beats with 'waits' wait cycles before each ack; pc jumps to
  // redir_pc at the start of beat redir_beat (if non-negative).
  task automatic fill_beats(input logic [63:0] base, input int waits, input logic [31:0] salt,
                            input int nbeats, input int redir_beat, input logic [63:0] redir_pc);
    for (int k = 0; k < nbeats; k++) begin
      if (k == redir_beat) pc = redir_pc;
      for (int w = 0; w < waits; w++) begin
        @(negedge clk);
        m_ack  = 1'b0;
        m_data = {$urandom, $urandom};
        #1;
        check($sformatf("wait m_rd b%0d", k), 64'(m_rd), 64'd1);
        check($sformatf("wait m_addr b%0d", k), m_addr, base + 64'(8 * k));
      end
      @(negedge clk);
      m_ack  = 1'b1;
      m_data = word(k, salt);
      #1;
      check($sformatf("m_rd b%0d", k), 64'(m_rd), 64'd1);
      check($sformatf("m_addr b%0d", k), m_addr, base + 64'(8 * k));
      check($sformatf("b_dv in fill b%0d", k), 64'(b_dv), 64'd0);
    end
  endtask

  task automatic idle_cycle(input string tag, input logic rd);
    @(negedge clk);
    b_rd  = rd;
    m_ack = 1'b0;
    #1;
    check({tag, " idle m_rd"}, 64'(m_rd), 64'd0);
    check({tag, " idle b_dv"}, 64'(b_dv), 64'd0);
  endtask

  task automatic done_cycle(input string tag, input logic exp_dv);
    @(negedge clk);
    m_ack = 1'b0;
    #1;
    check({tag, " done m_rd"}, 64'(m_rd), 64'd0);
    check({tag, " done b_dv"}, 64'(b_dv), 64'(exp_dv));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset with a pending miss: nothing may start.
    clr_n  = 1'b0;
    b_rd   = 1'b1;
    pc     = 64'h0000_0000_8000_0104;
    m_ack  = 1'b0;
    m_data = '0;
    #1;
    check("rst m_rd", 64'(m_rd), 64'd0);
    check("rst b_dv", 64'(b_dv), 64'd0);
    check("rst m_addr", m_addr, 64'd0);
    check_line_zero("rst");
    repeat (2) @(negedge clk);
    check("rst hold m_rd", 64'(m_rd), 64'd0);
    b_rd  = 1'b0;
    clr_n = 1'b1;

    // Zero-wait fill, table driven: entry 0 is the request cycle, 1..16 FILL,
    // 17 DONE, 18 IDLE.
    vecs.push_back('{1'b1, 1'b1, 64'd0, 1'b0, 1'b0, 1'b1, 64'd0});
    for (int k = 0; k < NBEAT; k++)
      vecs.push_back('{1'b1, 1'b1, 64'(k), 1'b1, 1'b0, 1'b1, 64'h8000_0100 + 64'(8 * k)});
    vecs.push_back('{1'b1, 1'b1, 64'hdead, 1'b0, 1'b1, 1'b0, 64'd0});
    vecs.push_back('{1'b0, 1'b0, 64'hbeef, 1'b0, 1'b0, 1'b0, 64'd0});
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      b_rd   = vecs[i].b_rd;
      m_ack  = vecs[i].m_ack;
      m_data = vecs[i].m_data;
      #1;
      check($sformatf("zw m_rd c%0d", i), 64'(m_rd), 64'(vecs[i].exp_m_rd));
      check($sformatf("zw b_dv c%0d", i), 64'(b_dv), 64'(vecs[i].exp_b_dv));
      if (vecs[i].chk_addr)
        check($sformatf("zw m_addr c%0d", i), m_addr, vecs[i].exp_m_addr);
    end
    check_line("zw", 32'd0);

    // Two wait states before every beat: DONE lands in cycle 49.
    pc = 64'h0000_0012_3456_7A9C;
    idle_cycle("ws", 1'b1);
    fill_beats(64'h0000_0012_3456_7A80, 2, 32'h5a5a_0001, NBEAT, -1, '0);
    done_cycle("ws", 1'b1);
    check_line("ws", 32'h5a5a_0001);
    idle_cycle("ws post", 1'b0);

    // Redirect to another line at beat 5: burst finishes on the old line, no
    // b_dv, then the new line starts after one IDLE cycle.
    pc = 64'h0000_0000_8000_0104;
    idle_cycle("rd", 1'b1);
    fill_beats(64'h0000_0000_8000_0100, 0, 32'h0000_00a1, NBEAT, 5, 64'h0000_0000_8000_0208);
    done_cycle("rd", 1'b0);
    check_line("rd", 32'h0000_00a1);
    idle_cycle("rd gap", 1'b1);
    fill_beats(64'h0000_0000_8000_0200, 0, 32'h0000_00a2, NBEAT, -1, '0);
    done_cycle("rd new", 1'b1);
    check_line("rd new", 32'h0000_00a2);
    idle_cycle("rd post", 1'b0);

    // Asynchronous reset at beat 8, then a clean restart from beat 0.
    pc = 64'h0000_0000_4000_0010;
    idle_cycle("ra", 1'b1);
    fill_beats(64'h0000_0000_4000_0000, 0, 32'h0000_00b1, 8, -1, '0);
    @(negedge clk);
    m_ack = 1'b0;
    #1;
    check("ra beat8 m_rd", 64'(m_rd), 64'd1);
    check("ra beat8 m_addr", m_addr, 64'h0000_0000_4000_0040);
    #2;
    clr_n = 1'b0;
    #1;
    check("ra async m_rd", 64'(m_rd), 64'd0);
    check("ra async b_dv", 64'(b_dv), 64'd0);
    check_line_zero("ra");
    @(negedge clk);
    clr_n = 1'b1;
    b_rd  = 1'b1;
    #1;
    check("ra release m_rd", 64'(m_rd), 64'd0);
    fill_beats(64'h0000_0000_4000_0000, 0, 32'h0000_00b2, NBEAT, -1, '0);
    done_cycle("ra", 1'b1);
    check_line("ra", 32'h0000_00b2);

    // Back-to-back: second miss raised in the IDLE cycle right after DONE.
    pc = 64'h0000_0000_0001_0000;
    idle_cycle("bb gap0", 1'b0);
    idle_cycle("bb a", 1'b1);
    fill_beats(64'h0000_0000_0001_0000, 0, 32'h0000_00c1, NBEAT, -1, '0);
    done_cycle("bb a", 1'b1);
    pc = 64'h0000_0000_0001_0080;
    idle_cycle("bb gap", 1'b1);
    fill_beats(64'h0000_0000_0001_0080, 0, 32'h0000_00c2, NBEAT, -1, '0);
    done_cycle("bb b", 1'b1);
    check_line("bb b", 32'h0000_00c2);
    idle_cycle("bb post", 1'b0);

    // b_rd dropped before DONE: line lands in the buffer but is not delivered.
    pc = 64'h0000_0000_0002_0000;
    idle_cycle("dr", 1'b1);
    fill_beats(64'h0000_0000_0002_0000, 0, 32'h0000_00d1, NBEAT, -1, '0);
    b_rd = 1'b0;
    done_cycle("dr", 1'b0);
    idle_cycle("dr post", 1'b0);
    check_line("dr", 32'h0000_00d1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_fill.md
# imem_fill

Line-fill engine between the hart's instruction cache and the memory bus. On a cache miss (`b_rd`) it captures the missing line address from `pc`, reads the 1024-bit line as 16 sequential 64-bit beats over a request/acknowledge memory port, and assembles them into a line buffer. It then presents the whole line on `b_data` with a one-cycle `b_dv` pulse, which the cache uses to refill.

## Interface
- `LINE_W`, 1024, cache line width in bits
- `BEAT_W`, 64, memory beat width in bits; beats per line `NBEAT = LINE_W/BEAT_W` = 16
- `clk` in 1: clock
- `clr_n` in 1: reset, asynchronous, active-low
- `pc` in 64: current fetch address; line address is `pc[63:7]`
- `b_rd` in 1: cache miss, line requested
- `b_data` out 1024: assembled line, byte 0 in bits [7:0]
- `b_dv` out 1: line valid, single-cycle pulse
- `m_addr` out 64: beat address, 8-byte aligned
- `m_rd` out 1: beat read request
- `m_data` in 64: beat read data
- `m_ack` in 1: beat data valid; a beat completes on a `clk` edge where `m_rd && m_ack`

## Operation
- States: IDLE, FILL, DONE.
- IDLE:
  - `m_rd` = 0 and `b_dv` = 0.
  - If `b_rd` = 1 at a clock edge: latch `line <= pc[63:7]`, set `beat <= 0`, go to FILL.
- FILL:
  - `m_rd` = 1 and `m_addr = {line, beat[3:0], 3'b000}`.
  - `m_addr` is held stable until the beat is acknowledged.
  - On `m_ack`: write `buf[beat*64 +: 64] <= m_data` and increment `beat`.
  - On `m_ack` with `beat` = 15: go to DONE.
  - Once started, a burst always runs to completion. `b_rd` and `pc` are ignored in FILL.
- DONE:
  - `b_data = buf`.
  - `b_dv = b_rd && (pc[63:7] == line)`. This is combinational and lasts exactly one cycle.
  - Next state is unconditionally IDLE.
  - If `pc` moved to another line, or `b_rd` dropped, the line is discarded silently (no `b_dv`). This prevents the cache writing stale data under a wrong tag.
- `b_data` always reflects `buf` and is stable outside FILL. `buf` is only written in FILL.
- `beat` counter is 4 bits; it wraps to 0 after beat 15, coinciding with the transition to DONE.
- If `b_rd` is high in the cycle after DONE (cache missed again on a new line, or the line was discarded), a new fill starts from IDLE with the `pc` line current at that time.

## Timing
- Reset values: state IDLE, `m_rd` = 0, `m_addr` = 0, `b_dv` = 0, `beat` = 0, `line` = 0, `buf` = 0 (so `b_data` = 0).
- Reset mid-fill: the abort is asynchronous. `m_rd` drops immediately, partial beats are discarded, and no `b_dv` is issued.
- Minimum latency with zero-wait memory (`m_ack` tied high):
  - `b_rd` sampled at edge 0.
  - FILL during cycles 1–16, one beat per cycle.
  - DONE in cycle 17; `b_dv` is high during cycle 17.
  - The cache captures the line at the end of cycle 17.
- Each wait-state cycle (`m_rd` high, `m_ack` low) adds one cycle.
- One mandatory IDLE cycle separates consecutive fills.
- `m_rd` and `m_addr` are registered state-decoded outputs. There is no combinational path from `m_ack` to `m_rd` or `m_addr`.
- `b_dv` is combinational from `pc` and `b_rd`, but only in DONE.

## Structure
- Shared hart package holds: `LINE_W`, `BEAT_W`, `NBEAT`, `OFFS_W` = 7, and the state enumeration constants (IDLE = 2'd0, FILL = 2'd1, DONE = 2'd2).
- The cache uses the same `LINE_W`/`OFFS_W` constants.
- Single module. The line buffer is a 1024-bit register with beat-indexed write enables, kept inline. No sub-module.

## Test plan
- **Reset state:** Assert `clr_n` = 0 with `b_rd` = 1 → `m_rd` = 0, `b_dv` = 0, `b_data` = 0. After release, the first `m_addr` follows on the next edge.
- **Zero-wait fill:**
  - Stimulus: `pc` = 0x0000_0000_8000_0104, `b_rd` = 1, `m_ack` = 1, `m_data` = beat index replicated.
  - `m_addr` must go 0x8000_0100, 0x…108, … 0x…178 over 16 consecutive cycles.
  - `b_dv` must pulse in cycle 17, with `b_data[64*k +: 64]` = k for every k.
- **Wait states:** `m_ack` low for 2 cycles before each beat → each `m_addr` held 3 cycles, `b_dv` in cycle 49, data correct.
- **Redirect mid-fill:** `pc` changes to line 0x…0200 at beat 5 with `b_rd` still high → burst completes at line 0x…0100, no `b_dv`. The next fill starts at `m_addr` 0x…0200 one cycle after DONE.
- **Reset mid-fill:** Drop `clr_n` asynchronously at beat 8 → `m_rd` falls the same cycle, `b_data` = 0. After release with `b_rd` = 1, the fill restarts from beat 0.
- **Back-to-back misses:** Two lines requested back-to-back → exactly one IDLE cycle between the DONE of the first fill and the first `m_rd` of the second; each `b_dv` is exactly one cycle wide.
